chip8_loader: RTL and testbench
===============================

# chip8_loader

Upstream program loader for the CHIP-8 interpreter. Consumes the UART receive byte stream (`rx_i`/`rx_i_v`), parses a framed program image, and writes it into interpreter program memory starting at address 0x200. It holds the interpreter stopped (`run` low) until a complete image with a matching checksum is stored.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: program memory address width.
- `DATA_WIDTH`, 8: memory/byte width.
- `LOAD_BASE`, 512: first write address.
- `TIMEOUT_CYCLES`, 1000000: maximum clk cycles allowed between bytes inside a frame.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `rx_i` in 8: received byte, valid when `rx_i_v` high.
- `rx_i_v` in 1: single-cycle strobe per byte. Back-to-back strobes on consecutive cycles are legal.
- `mem_we` out 1: program memory write strobe.
- `mem_waddr` out ADDR_WIDTH: write address.
- `mem_d` out DATA_WIDTH: write data.
- `busy` out 1: a frame is in progress.
- `run` out 1: image loaded and verified; interpreter may execute.
- `err` out 1: last frame aborted.
- `err_code` out 2: 0 none, 1 bad length, 2 checksum mismatch, 3 inter-byte timeout.

## Operation
- Frame format: SYNC (0xC8), LEN_H, LEN_L, LEN payload bytes, CSUM. CSUM is the mod-256 sum of the payload.
- States:
  - IDLE: non-SYNC bytes are ignored; SYNC goes to LEN_H.
  - LEN_H goes to LEN_L.
  - LEN_L: if {LEN_H,LEN_L} is 0 or greater than 4096−LOAD_BASE (3584), go to ERR with code 1. Otherwise go to DATA.
  - DATA: write each byte, then increment the address and decrement the remaining count. After the last byte, go to CSUM.
  - CSUM: go to DONE if the byte equals the running sum, else ERR with code 2.
  - DONE and ERR: a SYNC byte restarts the frame (goes to LEN_H, clears `err`/`err_code`, drops `run`). Other bytes are ignored.
- The running sum and write address are initialised on SYNC (sum 0, address LOAD_BASE).
- The address never wraps: a max-length image ends at 0xFFF.
- A SYNC value arriving inside LEN_H..CSUM is treated as ordinary data, not resync.
- Timeout: a gap counter clears on every `rx_i_v` and counts only in LEN_H..CSUM. When it reaches TIMEOUT_CYCLES−1 with no byte, go to ERR with code 3. A byte arriving on that same cycle wins: it is accepted and the counter clears.
- `busy` is high in LEN_H, LEN_L, DATA and CSUM. `run` is high only in DONE. `err` is high only in ERR.
- Nothing is written outside DATA. Bytes already written by an aborted frame stay in memory; `run` stays low.

## Timing
- Reset values: state IDLE, `mem_we` 0, `mem_waddr` LOAD_BASE, `mem_d` 0, `busy` 0, `run` 0, `err` 0, `err_code` 0. Gap counter, sum and count are all 0.
- Reset mid-frame drops everything immediately (asynchronous) and returns to IDLE.
- All outputs are registered.
- A payload byte accepted at cycle N produces `mem_we`=1 with `mem_waddr`/`mem_d` at cycle N+1, as a one-cycle pulse per byte. Consecutive strobes give consecutive writes.
- `run`, or `err` with its code, asserts at N+1 after the deciding byte at cycle N.
- Timeout: `err` asserts the cycle after the counter hits TIMEOUT_CYCLES−1.
- Restart from DONE/ERR: `run`/`err` fall at N+1 after SYNC at N.
- Throughput: one byte per cycle, no backpressure.

## Structure
- Shared `chip8_pkg` holds:
  - SYNC_BYTE (8'hC8) and the LOAD_BASE default;
  - the state enumeration (IDLE, LEN_H, LEN_L, DATA, CSUM, DONE, ERR);
  - error code constants ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT.
- One sub-module, `gap_timer`: a counter with clear/enable inputs and an `expired` output, width clog2(TIMEOUT_CYCLES).
- The parser FSM, address/count/sum registers and output registers stay in the top module.

## Test plan
- Frame C8 00 03 11 22 33 66 sent back-to-back:
  - writes 0x200=11, 0x201=22, 0x202=33, each on the cycle after its byte;
  - `run`=1 one cycle after 66; `busy` falls; `err`=0.
- Same frame with CSUM 67: three writes occur, `err`=1, `err_code`=2, `run`=0.
- LEN=0x0E01 (3585): no writes, `err_code`=1. LEN=0x0E00 of all 0x01 with CSUM 0x00: last write at 0xFFF, `run`=1.
- TIMEOUT_CYCLES=16; send C8 00 02 AA then stall: `err_code`=3 exactly 16 cycles after AA. A byte on the 15th idle cycle instead is accepted and no error is raised.
- In IDLE, send 55 C8 00 01 C8 C8: the 55 is ignored, the payload C8 is written to 0x200, `run`=1.
- Assert `rst_n` low mid-DATA: outputs go to reset values immediately. After release, a fresh frame loads again from 0x200.

Source files
------------

// File: rtl/chip8_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chip8_pkg: constants and types shared by the CHIP-8 program loader
// Rev 1.0
// ---------------------------------------------------------------------------
package chip8_pkg;

   localparam logic [7:0] SYNC_BYTE         = 8'hC8;
   localparam int         LOAD_BASE_DEFAULT = 512;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN_H = 3'd1,
      LEN_L = 3'd2,
      DATA  = 3'd3,
      CSUM  = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } ldr_state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // A zero-length image is rejected as well as one that would run past the top of memory.
   function automatic logic len_legal(input logic [15:0] len, input int max_len);
      return (len != 16'd0) && (int'(len) <= max_len);
   endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_loader_gap_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gap_timer: counts idle cycles while enabled; expired at TIMEOUT_CYCLES-1
// Rev 1.0
// ---------------------------------------------------------------------------
module gap_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

   logic [c_cnt_w-1:0] cnt_q;
   logic [c_cnt_w-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != c_last)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/chip8_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chip8_loader: parses framed UART program images into memory at LOAD_BASE
// Rev 1.0
// ---------------------------------------------------------------------------
module chip8_loader
   import chip8_pkg::*;
#(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 8,
   parameter int LOAD_BASE      = LOAD_BASE_DEFAULT,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_i,
   input  logic                  rx_i_v,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_d,
   output logic                  busy,
   output logic                  run,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam int                    c_max_len = (1 << ADDR_WIDTH) - LOAD_BASE;
   localparam logic [ADDR_WIDTH-1:0] c_base    = ADDR_WIDTH'(LOAD_BASE);

   ldr_state_e            state_q, state_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [15:0]           count_q, count_d;
   logic [7:0]            sum_q, sum_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;

   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
   logic [DATA_WIDTH-1:0] mem_d_q, mem_d_d;
   logic                  busy_q, busy_d;
   logic                  run_q, run_d;
   logic                  err_q, err_d;
   logic [1:0]            err_code_q, err_code_d;

   logic [15:0]           w_len;
   logic                  w_in_frame;
   logic                  w_expired;

   assign w_len      = {len_hi_q, rx_i};
   assign w_in_frame = state_q inside {LEN_H, LEN_L, DATA, CSUM};

   gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (rx_i_v),
      .en_i     (w_in_frame),
      .expired_o(w_expired)
   );

   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      count_d     = count_q;
      sum_d       = sum_q;
      addr_d      = addr_q;
      mem_we_d    = 1'b0;
      mem_waddr_d = mem_waddr_q;
      mem_d_d     = mem_d_q;
      err_code_d  = err_code_q;

      // A byte on the expiry cycle takes priority over the timeout.
      if (rx_i_v) begin
         unique case (state_q)
            IDLE, DONE, ERR: begin
               if (rx_i == SYNC_BYTE) begin
                  state_d    = LEN_H;
                  sum_d      = 8'd0;
                  addr_d     = c_base;
                  err_code_d = ERR_NONE;
               end
            end
            LEN_H: begin
               len_hi_d = rx_i;
               state_d  = LEN_L;
            end
            LEN_L: begin
               if (len_legal(w_len, c_max_len)) begin
                  count_d = w_len;
                  state_d = DATA;
               end else begin
                  state_d    = ERR;
                  err_code_d = ERR_LEN;
               end
            end
            DATA: begin
               mem_we_d    = 1'b1;
               mem_waddr_d = addr_q;
               mem_d_d     = DATA_WIDTH'(rx_i);
               sum_d       = sum_q + rx_i;
               count_d     = count_q - 16'd1;
               // Holding the address on the last byte keeps a full image from wrapping.
               if (count_q == 16'd1) begin
                  state_d = CSUM;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
            CSUM: begin
               if (rx_i == sum_q) begin
                  state_d = DONE;
               end else begin
                  state_d    = ERR;
                  err_code_d = ERR_CSUM;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (w_expired) begin
         state_d    = ERR;
         err_code_d = ERR_TIMEOUT;
      end

      busy_d = state_d inside {LEN_H, LEN_L, DATA, CSUM};
      run_d  = (state_d == DONE);
      err_d  = (state_d == ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_hi_q    <= 8'd0;
         count_q     <= 16'd0;
         sum_q       <= 8'd0;
         addr_q      <= c_base;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= c_base;
         mem_d_q     <= '0;
         busy_q      <= 1'b0;
         run_q       <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         len_hi_q    <= len_hi_d;
         count_q     <= count_d;
         sum_q       <= sum_d;
         addr_q      <= addr_d;
         mem_we_q    <= mem_we_d;
         mem_waddr_q <= mem_waddr_d;
         mem_d_q     <= mem_d_d;
         busy_q      <= busy_d;
         run_q       <= run_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_waddr = mem_waddr_q;
   assign mem_d     = mem_d_q;
   assign busy      = busy_q;
   assign run       = run_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_chip8_loader: frame-level reference model with scoreboarded status/writes
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_chip8_loader;

   localparam int TIMEOUT = 16;
   localparam int BASE    = 512;
   localparam int MAX_LEN = 4096 - BASE;

   // Status word: {busy, run, err, err_code}
   localparam logic [4:0] S_IDLE = 5'b00000;
   localparam logic [4:0] S_BUSY = 5'b10000;
   localparam logic [4:0] S_RUN  = 5'b01000;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        rx_i_v = 1'b0;
   logic [7:0]  rx_i   = 8'h00;
   logic        mem_we;
   logic [11:0] mem_waddr;
   logic [7:0]  mem_d;
   logic        busy, run, err;
   logic [1:0]  err_code;

   chip8_loader #(
      .ADDR_WIDTH    (12),
      .DATA_WIDTH    (8),
      .LOAD_BASE     (BASE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_i     (rx_i),
      .rx_i_v   (rx_i_v),
      .mem_we   (mem_we),
      .mem_waddr(mem_waddr),
      .mem_d    (mem_d),
      .busy     (busy),
      .run      (run),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   logic [4:0]  sq[$];
   logic [19:0] wq[$];
   logic [4:0]  exp_stat = S_IDLE;
   bit          in_frame = 1'b0;
   int          gap      = 0;
   logic [7:0]  pl[$];
   int          stall_at  = -1;
   int          stall_len = 0;
   int          rst_at    = -1;
   int          vectors     = 0;
   int          miscompares = 0;
   logic [4:0]  m_s;
   logic [19:0] m_w;

   function automatic logic [4:0] st_err(input logic [1:0] c);
      return {3'b001, c};
   endfunction

   // Monitor: status is checked every cycle, writes are popped as they appear.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (sq.size() > 0) begin
            m_s = sq.pop_front();
            vectors++;
            if ({busy, run, err, err_code} !== m_s) begin
               miscompares++;
               $display("FAIL status t=%0t got busy/run/err/code=%b expected %b",
                        $time, {busy, run, err, err_code}, m_s);
            end
         end
         if (mem_we === 1'b1) begin
            vectors++;
            if (wq.size() == 0) begin
               miscompares++;
               $display("FAIL write t=%0t unexpected write addr=%h data=%h", $time, mem_waddr, mem_d);
            end else begin
               m_w = wq.pop_front();
               if ({mem_waddr, mem_d} !== m_w) begin
                  miscompares++;
                  $display("FAIL write t=%0t got addr=%h data=%h expected addr=%h data=%h",
                           $time, mem_waddr, mem_d, m_w[19:8], m_w[7:0]);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_reset(input string name);
      vectors++;
      if ({mem_we, mem_waddr, mem_d, busy, run, err, err_code} !== {1'b0, 12'h200, 8'h00, 5'b00000}) begin
         miscompares++;
         $display("FAIL %s got we=%b addr=%h d=%h stat=%b expected we=0 addr=200 d=00 stat=00000",
                  name, mem_we, mem_waddr, mem_d, {busy, run, err, err_code});
      end
   endtask

   // One clock of stimulus; a silence of TIMEOUT cycles inside a frame aborts it.
   task automatic tick(input bit v, input logic [7:0] b);
      @(negedge clk);
      rx_i_v = v;
      rx_i   = b;
      if (in_frame) begin
         if (v) begin
            gap = 0;
         end else begin
            gap++;
            if (gap == TIMEOUT) begin
               exp_stat = st_err(2'd3);
               in_frame = 1'b0;
            end
         end
      end
      sq.push_back(exp_stat);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00);
   endtask

   // Sends SYNC, LEN, payload (pl) and csum; expectations derive from the frame's content.
   task automatic send_frame(input logic [15:0] len, input logic [7:0] csum, input int max_gap);
      logic [7:0] bytes[$];
      logic [7:0] s;
      bit         len_ok;
      len_ok = (len != 16'd0) && (int'(len) <= MAX_LEN);
      bytes  = {8'hC8, len[15:8], len[7:0]};
      if (len_ok) begin
         foreach (pl[k]) bytes.push_back(pl[k]);
         bytes.push_back(csum);
      end
      s = 8'h00;
      foreach (pl[k]) s += pl[k];
      for (int i = 0; i < bytes.size(); i++) begin
         if (i == rst_at) begin
            @(negedge clk);
            rx_i_v = 1'b0;
            rst_n  = 1'b0;
            #1;
            check_reset("mid_frame_reset");
            in_frame = 1'b0;
            gap      = 0;
            exp_stat = S_IDLE;
            wq.delete();
            idle(3);
            rst_n = 1'b1;
            return;
         end
         if (i == stall_at) begin
            idle(stall_len);
            if (stall_len >= TIMEOUT) return;
         end else if (i > 0) begin
            idle(int'($urandom_range(max_gap, 0)));
         end
         if (i == 0) begin
            exp_stat = S_BUSY;
            in_frame = 1'b1;
            gap      = 0;
         end else if (i == 2 && !len_ok) begin
            exp_stat = st_err(2'd1);
            in_frame = 1'b0;
         end else if (len_ok && i == bytes.size() - 1) begin
            exp_stat = (bytes[i] == s) ? S_RUN : st_err(2'd2);
            in_frame = 1'b0;
         end else if (i >= 3) begin
            wq.push_back({12'(BASE + i - 3), bytes[i]});
         end
         tick(1'b1, bytes[i]);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check_reset("reset_values");
      @(negedge clk);
      rst_n = 1'b1;

      pl = {8'h11, 8'h22, 8'h33};
      send_frame(16'd3, 8'h66, 0);
      idle(4);
      send_frame(16'd3, 8'h67, 0);
      idle(4);

      pl.delete();
      send_frame(16'h0E01, 8'h00, 0);
      idle(2);
      send_frame(16'h0000, 8'h00, 0);
      idle(2);

      tick(1'b1, 8'h55);
      pl = {8'hC8};
      send_frame(16'd1, 8'hC8, 0);
      idle(2);

      pl        = {8'hAA, 8'hBB};
      stall_at  = 4;
      stall_len = TIMEOUT;
      send_frame(16'd2, 8'h65, 0);
      idle(3);
      stall_len = TIMEOUT - 1;
      send_frame(16'd2, 8'h65, 0);
      stall_at = -1;
      idle(2);

      pl.delete();
      repeat (MAX_LEN) pl.push_back(8'h01);
      send_frame(16'(MAX_LEN), 8'h00, 0);
      idle(2);

      pl.delete();
      repeat (10) pl.push_back(8'($urandom));
      rst_at = 7;
      send_frame(16'd10, 8'h00, 1);
      rst_at = -1;
      idle(2);
      pl = {8'h11, 8'h22, 8'h33};
      send_frame(16'd3, 8'h66, 0);
      idle(2);

      for (int f = 0; f < 40; f++) begin
         int         len;
         logic [7:0] cs;
         logic [7:0] nb;
         if ($urandom_range(3, 0) == 0) begin
            nb = 8'($urandom);
            if (nb == 8'hC8) nb = 8'h00;
            tick(1'b1, nb);
         end
         len = int'($urandom_range(24, 1));
         pl.delete();
         cs = 8'h00;
         for (int k = 0; k < len; k++) begin
            pl.push_back(8'($urandom));
            cs += pl[k];
         end
         if ($urandom_range(3, 0) == 0) cs ^= 8'(1 << $urandom_range(7, 0));
         send_frame(16'(len), cs, 3);
         idle(1);
      end

      idle(4);
      @(negedge clk);
      vectors++;
      if (wq.size() != 0 || sq.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d writes and %0d status entries pending, expected 0 and 0",
                  wq.size(), sq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
